store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer.sv | 120 ++++++++++++
 tb/tb_store_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Bundles the CPU-side and data-memory-side signals of the store buffer.
// The slave modport is the buffer; the master modport is the CPU plus data memory.
interface store_buffer_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        memWrite;
  logic        memRead;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_rdata;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  modport slave (
    input  cpu_addr, cpu_wdata, memWrite, memRead, mem_rdata,
    output cpu_rdata, stall, mem_addr, mem_wdata, mem_memWrite, mem_memRead,
           count, empty, full
  );

  modport master (
    output cpu_addr, cpu_wdata, memWrite, memRead, mem_rdata,
    input  cpu_rdata, stall, mem_addr, mem_wdata, mem_memWrite, mem_memRead,
           count, empty, full
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between the CPU and data memory; loads take the memory port first.
// Define STORE_BUFFER_FWD_EN to forward buffered store data to matching loads instead of stalling.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave sb
);

  localparam int PW = $clog2(DEPTH);

  logic [29:0]   tagMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [4:0]    cnt;

  logic          hit;
  logic [PW-1:0] hitSlot;
  logic          enq;
  logic          deq;
  logic          unusedAddrBits;

  assign unusedAddrBits = ^sb.cpu_addr[1:0];

  assign sb.count = cnt;
  assign sb.empty = (cnt == 5'd0);
  assign sb.full  = (cnt == 5'(DEPTH));

  // Walk from the oldest entry so only slots holding live stores are compared.
  always_comb begin
    hit     = 1'b0;
    hitSlot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hitSlot = head + PW'(k);
      if ((5'(k) < cnt) && (tagMem[hitSlot] == sb.cpu_addr[31:2])) begin
        hit = 1'b1;
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [31:0]   fwdData;
  logic [PW-1:0] fwdSlot;

  // Later matches overwrite earlier ones, leaving the youngest store's data.
  always_comb begin
    fwdData = '0;
    fwdSlot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwdSlot = head + PW'(k);
      if ((5'(k) < cnt) && (tagMem[fwdSlot] == sb.cpu_addr[31:2])) begin
        fwdData = dataMem[fwdSlot];
      end
    end
  end

  assign sb.stall = sb.memWrite && sb.full;
`else
  assign sb.stall = (sb.memWrite && sb.full) || (sb.memRead && hit);
`endif

  assign enq = sb.memWrite && !sb.stall;

  always_comb begin
    sb.mem_memWrite = 1'b0;
    sb.mem_memRead  = 1'b0;
    sb.mem_addr     = '0;
    sb.mem_wdata    = '0;
    deq             = 1'b0;
    if (!rst) begin
      if (sb.memRead && !sb.stall) begin
        sb.mem_memRead = 1'b1;
        sb.mem_addr    = {sb.cpu_addr[31:2], 2'b00};
      end else if (cnt != 5'd0) begin
        sb.mem_memWrite = 1'b1;
        sb.mem_addr     = {tagMem[head], 2'b00};
        sb.mem_wdata    = dataMem[head];
        deq             = 1'b1;
      end
    end
  end

  always_comb begin
    sb.cpu_rdata = '0;
    if (sb.memRead) begin
`ifdef STORE_BUFFER_FWD_EN
      sb.cpu_rdata = hit ? fwdData : sb.mem_rdata;
`else
      sb.cpu_rdata = sb.mem_rdata;
`endif
    end
  end

  // Entry storage needs no reset: a cleared count makes stale slots invisible.
  always_ff @(posedge clk) begin
    if (enq) begin
      tagMem[tail]  <= sb.cpu_addr[31:2];
      dataMem[tail] <= sb.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      cnt <= cnt + 5'(enq) - 5'(deq);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-level model predicts each cycle,
// a negedge monitor compares. Build with STORE_BUFFER_FWD_EN to check the forwarding variant.
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [29:0] tag;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    bit rstCyc;
    bit stall;
    bit mw;
    bit mr;
    bit idle;
    bit emp;
    bit ful;
    int cnt;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;

  store_buffer_if sbIf();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .sb (sbIf)
  );

  always #5 clk = ~clk;

  entry_t      mq[$];
  xfer_t       writeQ[$];
  xfer_t       loadQ[$];
  cyc_t        cycQ[$];
  logic [31:0] dmem   [256];
  logic [31:0] refMem [256];
  int          checks = 0;
  int          passes = 0;

  assign sbIf.mem_rdata = dmem[sbIf.mem_addr[9:2]];

  // Data memory: one process owns it, initialising and then taking writes.
  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'hC0DE_0000 | i;
    forever begin
      @(posedge clk);
      if (sbIf.mem_memWrite === 1'b1) dmem[sbIf.mem_addr[9:2]] = sbIf.mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compares per-cycle status and pops transfers whenever the DUT presents one.
  always @(negedge clk) begin
    cyc_t  e;
    xfer_t x;
    if (cycQ.size() > 0) begin
      e = cycQ.pop_front();
      if (e.rstCyc) begin
        checkOutput("rst_mem_write", sbIf.mem_memWrite, 0);
      end else begin
        checkOutput("stall", sbIf.stall, e.stall);
        checkOutput("count", sbIf.count, e.cnt);
        checkOutput("empty", sbIf.empty, e.emp);
        checkOutput("full", sbIf.full, e.ful);
        checkOutput("mem_memWrite", sbIf.mem_memWrite, e.mw);
        checkOutput("mem_memRead", sbIf.mem_memRead, e.mr);
        if (!sbIf.memRead) checkOutput("cpu_rdata_noload", sbIf.cpu_rdata, 0);
        if (e.idle) begin
          checkOutput("idle_mem_addr", sbIf.mem_addr, 0);
          checkOutput("idle_mem_wdata", sbIf.mem_wdata, 0);
        end
      end
      if (sbIf.mem_memWrite === 1'b1) begin
        if (writeQ.size() == 0) failNow("unexpected_mem_write");
        else begin
          x = writeQ.pop_front();
          checkOutput("write_addr", sbIf.mem_addr, x.addr);
          checkOutput("write_data", sbIf.mem_wdata, x.data);
        end
      end
      if (!e.rstCyc && sbIf.memRead && (sbIf.stall === 1'b0)) begin
        if (loadQ.size() == 0) failNow("unexpected_load");
        else begin
          x = loadQ.pop_front();
          checkOutput("load_addr", sbIf.mem_addr, x.addr);
          checkOutput("load_data", sbIf.cpu_rdata, x.data);
        end
      end
    end
  end

  // One clock of stimulus; the model predicts this cycle's behaviour and its next state.
  task automatic stepCycle(input bit w, input bit r, input bit rstIn,
                           input logic [31:0] addr, input logic [31:0] data,
                           output bit stalled);
    cyc_t   e;
    entry_t f;
    bit     hit;
    bit     ful;
    logic [31:0] fwd;
    e = '{default: 0};
    sbIf.memWrite  = w;
    sbIf.memRead   = r;
    sbIf.cpu_addr  = addr;
    sbIf.cpu_wdata = data;
    rst            = rstIn;
    ful   = (mq.size() == DEPTH);
    e.cnt = mq.size();
    e.emp = (mq.size() == 0);
    e.ful = ful;
    stalled = 1'b0;
    if (rstIn) begin
      e.rstCyc = 1'b1;
      mq.delete();
    end else begin
      hit = 1'b0;
      fwd = '0;
      foreach (mq[i]) if (mq[i].tag == addr[31:2]) begin hit = 1'b1; fwd = mq[i].data; end
      stalled = (w && ful) || (r && hit && !FWD);
      e.stall = stalled;
      if (r && !stalled) begin
        e.mr = 1'b1;
        loadQ.push_back('{addr & 32'hFFFF_FFFC, (FWD && hit) ? fwd : refMem[addr[9:2]]});
      end else if (mq.size() > 0) begin
        e.mw = 1'b1;
        f = mq.pop_front();
        refMem[f.tag[7:0]] = f.data;
        writeQ.push_back('{{f.tag, 2'b00}, f.data});
      end else begin
        e.idle = 1'b1;
      end
      if (w && !stalled) mq.push_back('{addr[31:2], data});
    end
    cycQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Issues one CPU instruction, holding it while the model predicts a stall.
  task automatic applyStimulus(input bit w, input bit r, input logic [31:0] addr,
                               input logic [31:0] data);
    bit st;
    int n = 0;
    do begin
      stepCycle(w, r, 1'b0, addr, data, st);
      n++;
    end while (st && n < 40);
    if (st) failNow("stall_timeout");
  endtask

  task automatic idleCycles(input int n);
    bit st;
    for (int i = 0; i < n; i++) stepCycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, st);
  endtask

  initial begin
    bit st;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) refMem[i] = 32'hC0DE_0000 | i;
    rst            = 1'b1;
    sbIf.memWrite  = 1'b0;
    sbIf.memRead   = 1'b0;
    sbIf.cpu_addr  = '0;
    sbIf.cpu_wdata = '0;
    @(posedge clk);
    #1;
    stepCycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, st);
    stepCycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, st);
    idleCycles(1);

    applyStimulus(1'b1, 1'b0, 32'h10, 32'h11);
    idleCycles(3);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 32'h300 + 4 * i, 32'h3000 + i);
    idleCycles(6);

    applyStimulus(1'b1, 1'b0, 32'h20, 32'hAA);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'hBB);
    applyStimulus(1'b0, 1'b1, 32'h23, 32'h0);
    idleCycles(3);

    applyStimulus(1'b1, 1'b0, 32'h44, 32'h5555);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h0);
    idleCycles(3);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h200 + 4 * i, 32'h1000 + i);
      if (i % 3 == 2) idleCycles(1);
    end
    idleCycles(4);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h280 + 4 * i, 32'h2800 + i);
    stepCycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, st);
    idleCycles(4);
    applyStimulus(1'b0, 1'b1, 32'h200, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h280, 32'h0);
    idleCycles(2);

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 99) == 0) stepCycle(1'b0, 1'b0, 1'b1, a, 32'h0, st);
      else applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, $urandom);
    end
    idleCycles(8);

    checkOutput("writes_left", writeQ.size(), 0);
    checkOutput("loads_left", loadQ.size(), 0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
